// File: rtl/shift_pipe_unit_if.sv
// Request/response bundle for shift_pipe_unit: issue-side handshake, flush,
// and the registered result handshake toward writeback/forwarding.
interface shift_pipe_unit_if #(
    parameter int unsigned OPERAND_WIDTH = 16,
    parameter int unsigned SHAMT_WIDTH   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] in_data;
    logic [SHAMT_WIDTH-1:0]   in_shamt;
    logic [2:0]               in_op;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] out_data;
    logic                     out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_op, flush, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, flush, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shift_pipe_unit.sv
// Two-stage pipelined 16-bit shift/rotate unit: stage A shifts by amount[1:0],
// stage B by amount[3:2]*4. Define SHIFT_PIPE_ROTATE_EN to make ROL/ROR legal.
module shift_pipe_unit #(
    parameter int unsigned OPERAND_WIDTH = 16,
    parameter int unsigned SHAMT_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_pipe_unit_if.slave   bus
);

    localparam int unsigned W  = OPERAND_WIDTH;
    localparam int unsigned SW = SHAMT_WIDTH;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
`ifdef SHIFT_PIPE_ROTATE_EN
            OP_ROL, OP_ROR:         op_legal = 1'b1;
`endif
            default:                op_legal = 1'b0;
        endcase
    endfunction

    // Illegal ops fall through to the default arm and pass the value unchanged.
    function automatic logic [W-1:0] shift_by(input logic [W-1:0]  v,
                                              input logic [SW-1:0] amt,
                                              input logic [2:0]    op);
`ifdef SHIFT_PIPE_ROTATE_EN
        logic [2*W-1:0] dbl;
        dbl = {v, v};
`endif
        case (op)
            OP_SLL:  shift_by = v << amt;
            OP_SRL:  shift_by = v >> amt;
            OP_SRA:  shift_by = W'($signed(v) >>> amt);
`ifdef SHIFT_PIPE_ROTATE_EN
            OP_ROL: begin
                dbl      = dbl << amt;
                shift_by = dbl[2*W-1:W];
            end
            OP_ROR: begin
                dbl      = dbl >> amt;
                shift_by = dbl[W-1:0];
            end
`endif
            default: shift_by = v;
        endcase
    endfunction

    logic          a_valid_q, a_valid_d;
    logic [W-1:0]  a_part_q,  a_part_d;
    logic [1:0]    a_shamt_hi_q, a_shamt_hi_d;
    logic [2:0]    a_op_q,    a_op_d;
    logic          a_err_q,   a_err_d;
    logic          b_valid_q, b_valid_d;
    logic [W-1:0]  b_data_q,  b_data_d;
    logic          b_err_q,   b_err_d;

    logic          b_free;
    logic          a_open;
    logic          accept;
    logic          advance;

    assign b_free  = !b_valid_q || bus.out_ready;
    assign a_open  = !a_valid_q || b_free;
    assign accept  = bus.in_valid && bus.in_ready;
    assign advance = a_valid_q && b_free;

    assign bus.in_ready  = a_open && !bus.flush;
    assign bus.out_valid = b_valid_q;
    assign bus.out_data  = b_data_q;
    assign bus.out_err   = b_err_q;

    // Next-state for both stages; data registers only load on accept/advance.
    always_comb begin
        a_valid_d    = a_valid_q;
        a_part_d     = a_part_q;
        a_shamt_hi_d = a_shamt_hi_q;
        a_op_d       = a_op_q;
        a_err_d      = a_err_q;
        b_valid_d    = b_valid_q;
        b_data_d     = b_data_q;
        b_err_d      = b_err_q;

        if (a_open) begin
            a_valid_d = accept;
        end
        if (accept) begin
            a_part_d     = shift_by(bus.in_data, SW'(bus.in_shamt[1:0]), bus.in_op);
            a_shamt_hi_d = bus.in_shamt[3:2];
            a_op_d       = bus.in_op;
            a_err_d      = !op_legal(bus.in_op);
        end

        if (b_free) begin
            b_valid_d = a_valid_q;
        end
        if (advance) begin
            b_data_d = shift_by(a_part_q, SW'({a_shamt_hi_q, 2'b00}), a_op_q);
            b_err_d  = a_err_q;
        end

        if (bus.flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q    <= 1'b0;
            a_part_q     <= '0;
            a_shamt_hi_q <= '0;
            a_op_q       <= '0;
            a_err_q      <= 1'b0;
            b_valid_q    <= 1'b0;
            b_data_q     <= '0;
            b_err_q      <= 1'b0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_part_q     <= a_part_d;
            a_shamt_hi_q <= a_shamt_hi_d;
            a_op_q       <= a_op_d;
            a_err_q      <= a_err_d;
            b_valid_q    <= b_valid_d;
            b_data_q     <= b_data_d;
            b_err_q      <= b_err_d;
        end
    end

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Directed, table-driven bench for shift_pipe_unit; rotate expectations follow
// SHIFT_PIPE_ROTATE_EN so the same bench covers both builds.
module tb_shift_pipe_unit;

`ifdef SHIFT_PIPE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_pipe_unit_if bus ();

    shift_pipe_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic [3:0]  shamt;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d,
                         input logic [3:0] sh);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = sh;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{3'b001, 16'h8000, 4'd15, 16'h0001, 1'b0};
        vecs[1]  = '{3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0};
        vecs[2]  = '{3'b010, 16'h8000, 4'd4,  16'hF800, 1'b0};
        vecs[3]  = '{3'b010, 16'h7FF0, 4'd4,  16'h07FF, 1'b0};
        vecs[4]  = '{3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
        vecs[5]  = '{3'b000, 16'h1234, 4'd0,  16'h1234, 1'b0};
        vecs[6]  = '{3'b001, 16'hABCD, 4'd4,  16'h0ABC, 1'b0};
        vecs[7]  = '{3'b000, 16'h00FF, 4'd6,  16'h3FC0, 1'b0};
        vecs[8]  = '{3'b010, 16'h9000, 4'd3,  16'hF200, 1'b0};
        vecs[9]  = '{3'b011, 16'h8001, 4'd1,  ROT ? 16'h0003 : 16'h8001, !ROT};
        vecs[10] = '{3'b100, 16'h0001, 4'd12, ROT ? 16'h0010 : 16'h0001, !ROT};
        vecs[11] = '{3'b011, 16'h1234, 4'd4,  ROT ? 16'h2341 : 16'h1234, !ROT};
        vecs[12] = '{3'b100, 16'h1234, 4'd0,  16'h1234, !ROT};
        vecs[13] = '{3'b111, 16'h1234, 4'd5,  16'h1234, 1'b1};
        vecs[14] = '{3'b101, 16'hBEEF, 4'd3,  16'hBEEF, 1'b1};

        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 3'b000, 16'h0000, 4'd0);
        #3;
        rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data",  32'(bus.out_data),  32'd0);
        check("reset_out_err",   32'(bus.out_err),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Single requests, one at a time, out_ready high.
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt);
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(vecs[i].exp_err));
        end
        tick();
        check("drain_idle", 32'(bus.out_valid), 32'd0);

        // Throughput: 8 back-to-back requests, SLL 1 by c.
        for (int c = 0; c < 10; c++) begin
            if (c == 1) check("tput_not_yet", 32'(bus.out_valid), 32'd0);
            if (c >= 2) begin
                check($sformatf("tput%0d_valid", c - 2), 32'(bus.out_valid), 32'd1);
                check($sformatf("tput%0d_data", c - 2),  32'(bus.out_data),  32'd1 << (c - 2));
            end
            if (c < 8) begin
                drive(1'b1, 3'b000, 16'h0001, 4'(c));
                check($sformatf("tput%0d_in_ready", c), 32'(bus.in_ready), 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        check("tput_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure: two accepted, third stalls until out_ready returns.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001, 16'hF000, 4'd4);
        check("bp_r0_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 3'b000, 16'h0003, 4'd8);
        check("bp_r1_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 3'b010, 16'h8000, 4'd1);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        check("bp_r0_data",    32'(bus.out_data), 32'h0F00);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("bp_stall%0d_ready", k), 32'(bus.in_ready),  32'd0);
            check($sformatf("bp_stall%0d_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_stall%0d_data", k),  32'(bus.out_data),  32'h0F00);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_r1_data", 32'(bus.out_data), 32'h0300);
        tick();
        check("bp_r2_valid", 32'(bus.out_valid), 32'd1);
        check("bp_r2_data",  32'(bus.out_data),  32'hC000);
        tick();
        check("bp_idle", 32'(bus.out_valid), 32'd0);

        // Flush with both stages full.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b000, 16'h0001, 4'd1);
        tick();
        drive(1'b1, 3'b000, 16'h0001, 4'd2);
        tick();
        drive(1'b1, 3'b000, 16'h0001, 4'd3);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready),  32'd0);
        check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("flush_a_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001, 16'h00F0, 4'd4);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("post_flush_valid", 32'(bus.out_valid), 32'd1);
        check("post_flush_data",  32'(bus.out_data),  32'h000F);
        tick();

        // Illegal op held in B, then asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 16'h1234, 4'd0);
        tick();
        drive(1'b1, 3'b000, 16'h00FF, 4'd1);
        tick();
        bus.in_valid = 1'b0;
        check("ill_data", 32'(bus.out_data), 32'h1234);
        check("ill_err",  32'(bus.out_err),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_data",  32'(bus.out_data),  32'd0);
        check("rst_mid_err",   32'(bus.out_err),   32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("rst_mid_idle", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
